// File: rtl/high_fanout_add_sched.sv
// high_fanout_add_sched
//
// Purpose: shares one broadcast-add datapath among NUM_REQ requesters.
// Each cycle an arbiter picks one requester. Its operand runs through a
// 3-stage pipeline, and the result vector out[i] = operand + i (mod 2^DATA_WIDTH)
// leaves tagged with the requester index. The S2 operand is held in
// NUM_DUP duplicated registers so that no copy drives more than MAX_FANOUT adders.
//
// Arbitration build option:
//   HFA_SCHED_FIXED_PRIO_EN  defined   -> fixed priority (lowest index wins)
//                            undefined -> round-robin (default)
//
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   in_valid   per-requester request valid
//   in_data    per-requester operand
//   in_ready   per-requester accept (one-hot or zero)
//   out_valid  result vector valid
//   out_ready  consumer accepts result
//   out        result vector, out[i] = operand + i
//   out_id     requester index of current result
//   busy       any pipeline stage holds valid data
module high_fanout_add_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ADDERS = 4,
  parameter int MAX_FANOUT = 2,
  parameter int NUM_REQ    = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     in_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     in_data,
  output logic [NUM_REQ-1:0]                     in_ready,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [NUM_ADDERS-1:0][DATA_WIDTH-1:0]  out,
  output logic [$clog2(NUM_REQ)-1:0]             out_id,
  output logic                                   busy
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int NUM_DUP = (NUM_ADDERS + MAX_FANOUT - 1) / MAX_FANOUT;

  // Result wraps modulo 2^DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] wrap_add(input logic [DATA_WIDTH-1:0] a,
                                                     input int unsigned           k);
    return a + DATA_WIDTH'(k);
  endfunction

  logic                  stall;
  logic                  found;
  logic [ID_W-1:0]       gnt_idx;
  logic                  xfer;

  logic                  vld_p1_q;
  logic [DATA_WIDTH-1:0] op_p1_q;
  logic [ID_W-1:0]       id_p1_q;

  // Duplicates must survive synthesis to keep per-register fanout bounded.
  (* dont_merge *) logic [NUM_DUP-1:0][DATA_WIDTH-1:0] dup_p2_q;
  logic                  vld_p2_q;
  logic [ID_W-1:0]       id_p2_q;

  logic                                  out_vld_q;
  logic [NUM_ADDERS-1:0][DATA_WIDTH-1:0] out_q;
  logic [NUM_ADDERS-1:0][DATA_WIDTH-1:0] out_d;
  logic [ID_W-1:0]                       out_id_q;

  assign stall = out_vld_q && !out_ready;

`ifdef HFA_SCHED_FIXED_PRIO_EN
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && in_valid[i]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] ptr_q;

  // Rotating search from ptr+1: first scan indices above the pointer,
  // then wrap and scan from 0 up to and including the pointer.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && in_valid[i] && (i > int'(ptr_q))) begin
        found   = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && in_valid[i] && (i <= int'(ptr_q))) begin
        found   = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
  end

  // Pointer moves only on an actual transfer; reset gives requester 0 first priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= ID_W'(NUM_REQ - 1);
    end else if (xfer) begin
      ptr_q <= gnt_idx;
    end
  end
`endif

  // rst is folded in so no requester sees an accept while reset is asserted.
  assign xfer = found && !stall && rst;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      in_ready[i] = xfer && (gnt_idx == ID_W'(i));
    end
  end

  always_comb begin
    out_d = '0;
    for (int unsigned i = 0; i < NUM_ADDERS; i++) begin
      out_d[i] = wrap_add(dup_p2_q[i / MAX_FANOUT], i);
    end
  end

  // Control and output registers: cleared by reset, frozen (bubbles included) on stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
      out_id_q  <= '0;
    end else if (!stall) begin
      // S1 -> S2 -> S3 valid chain
      vld_p1_q  <= xfer;
      vld_p2_q  <= vld_p1_q;
      // S3: registered adder outputs
      out_vld_q <= vld_p2_q;
      out_q     <= out_d;
      out_id_q  <= id_p2_q;
    end
  end

  // Datapath registers carry no reset; their contents matter only under the valid bits.
  always_ff @(posedge clk) begin
    if (!stall) begin
      // S1: granted operand and id
      op_p1_q <= in_data[gnt_idx];
      id_p1_q <= gnt_idx;
      // S2: duplicated operand copies
      for (int j = 0; j < NUM_DUP; j++) begin
        dup_p2_q[j] <= op_p1_q;
      end
      id_p2_q <= id_p1_q;
    end
  end

  assign out_valid = out_vld_q;
  assign out       = out_q;
  assign out_id    = out_id_q;
  assign busy      = vld_p1_q | vld_p2_q | out_vld_q;

endmodule

// File: tb/tb_high_fanout_add_sched.sv
module tb_high_fanout_add_sched;

  localparam int DW = 8;
  localparam int NA = 4;
  localparam int MF = 2;
  localparam int NR = 3;
  localparam int IW = 2;
  localparam int DEPTH = 8192;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NR-1:0]         in_valid;
  logic [NR-1:0][DW-1:0] in_data;
  logic [NR-1:0]         in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [NA-1:0][DW-1:0] out;
  logic [IW-1:0]         out_id;
  logic                  busy;

  always #5 clk = ~clk;

  high_fanout_add_sched #(
    .DATA_WIDTH(DW),
    .NUM_ADDERS(NA),
    .MAX_FANOUT(MF),
    .NUM_REQ   (NR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .out_id   (out_id),
    .busy     (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: every non-stalled edge is one "slot". A slot records
  // what was accepted on that edge (or a bubble); the result for slot a is
  // presented while the slot counter equals a+3.
  bit  s_v [DEPTH];
  int  s_id[DEPTH];
  int  s_d [DEPTH];
  int  adv;
  int  mptr;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) s_v[i] = 1'b0;
    adv  = 0;
    mptr = NR - 1;
  endtask

  function automatic int pick(input logic [NR-1:0] v);
`ifdef HFA_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NR; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NR; k++) begin
      int j;
      j = (mptr + k) % NR;
      if (v[j]) return j;
    end
`endif
    return -1;
  endfunction

  function automatic logic [31:0] result_of(input int d);
    logic [31:0] e;
    e = '0;
    for (int i = 0; i < NA; i++) e[i*8 +: 8] = 8'((d + i) % 256);
    return e;
  endfunction

  // Drive one cycle at the negedge, check against the model, step the model.
  task automatic cycle(input logic [NR-1:0] v, input logic [NR-1:0][DW-1:0] d, input logic ordy);
    int            g;
    bit            ev;
    bit            st;
    bit            eb;
    logic [NR-1:0] er;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    ev = (adv >= 3) && s_v[adv-3];
    st = ev && !ordy;
    eb = ev || ((adv >= 1) && s_v[adv-1]) || ((adv >= 2) && s_v[adv-2]);
    g  = pick(v);
    er = '0;
    if (g >= 0 && !st) er[g] = 1'b1;
    chk("in_ready", in_ready, er);
    chk("out_valid", out_valid, ev);
    if (ev) begin
      chk("out", out, result_of(s_d[adv-3]));
      chk("out_id", out_id, s_id[adv-3]);
    end
    chk("busy", busy, eb);
    if (!st) begin
      s_v[adv] = (g >= 0);
      if (g >= 0) begin
        s_id[adv] = g;
        s_d[adv]  = d[g];
        mptr      = g;
      end
      adv++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [NR-1:0][DW-1:0] dd;

  task automatic rand_data();
    for (int i = 0; i < NR; i++) dd[i] = DW'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    in_valid  = '1;
    in_data   = '0;
    out_ready = 1'b1;
    dd        = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 3'b000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out", out, 32'h0);
    chk("rst_out_id", out_id, 2'd0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Round-robin with all requesters active, then drain
    repeat (6) begin rand_data(); cycle(3'b111, dd, 1'b1); end
    repeat (4) cycle(3'b000, dd, 1'b1);

    // Single request from requester 1
    dd = '0; dd[1] = 8'h10;
    cycle(3'b010, dd, 1'b1);
    repeat (2) cycle(3'b000, dd, 1'b1);
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_out", out, 32'h13121110);
    chk("t1_out_id", out_id, 2'd1);
    repeat (2) cycle(3'b000, dd, 1'b1);

    // Wrap-around of the adders
    dd = '0; dd[0] = 8'hFE;
    cycle(3'b001, dd, 1'b1);
    repeat (2) cycle(3'b000, dd, 1'b1);
    chk("t3_out", out, 32'h0100FFFE);
    chk("t3_out_id", out_id, 2'd0);
    repeat (2) cycle(3'b000, dd, 1'b1);

    // Back-pressure with a full pipeline
    repeat (4) begin rand_data(); cycle(3'b111, dd, 1'b1); end
    repeat (5) begin rand_data(); cycle(3'b111, dd, 1'b0); end
    repeat (3) begin rand_data(); cycle(3'b111, dd, 1'b1); end
    repeat (5) cycle(3'b000, dd, 1'b1);

    // Reset with results in flight
    repeat (3) begin rand_data(); cycle(3'b111, dd, 1'b1); end
    rst = 1'b0;
    #1;
    chk("t5_out_valid", out_valid, 1'b0);
    chk("t5_out", out, 32'h0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_in_ready", in_ready, 3'b000);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    rand_data();
    cycle(3'b111, dd, 1'b1);
    repeat (4) begin rand_data(); cycle(3'b111, dd, 1'b1); end

    // Fixed-priority fallback check (requester 0 dropped)
    repeat (3) begin rand_data(); cycle(3'b110, dd, 1'b1); end
    repeat (4) cycle(3'b000, dd, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rand_data();
      cycle(NR'($urandom), dd, ($urandom_range(3, 0) != 0));
    end
    repeat (6) cycle(3'b000, dd, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
